// File: rtl/key_note_scheduler.sv
// key_note_scheduler: queues debounced keypad events and plays each as a timed tone followed by a silent gap.
module key_note_scheduler #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int NOTE_LEN = 25_000_000,
  parameter int GAP_LEN  = 2_500_000,
  parameter int DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  key_code,
  output logic [17:0] tone_div,
  output logic        tone_en,
  output logic        busy,
  output logic [3:0]  fifo_count,
  output logic        overflow
);
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  typedef logic [15:0][17:0] table_t;
  localparam int MAXL = NOTE_LEN > GAP_LEN ? NOTE_LEN : GAP_LEN;
  localparam int CW = $clog2(MAXL) < 1 ? 1 : $clog2(MAXL);
  localparam int AW = $clog2(DEPTH);
  // Note frequencies C4..D6 in millihertz so the half-period rounds exactly in integer math
  localparam longint F_MHZ [16] = '{261626, 293665, 329628, 349228, 391995, 440000, 493883, 523251,
                                     587330, 659255, 698456, 783991, 880000, 987767, 1046502, 1174659};
  function automatic table_t build_table();
    table_t t;
    for (int i = 0; i < 16; i++)
      t[i] = 18'((longint'(CLK_HZ) * 1000 + F_MHZ[i]) / (2 * F_MHZ[i]));
    return t;
  endfunction
  localparam table_t TONES = build_table();
  state_t          r_state, w_next;
  logic [7:0]      r_s1, r_s2, r_last;
  logic [3:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [3:0]      r_count, r_note;
  logic            r_ovf;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic [17:0]     r_div;
  logic            w_valid, w_evt, w_full, w_push, w_pop;
  assign w_valid = r_s2[5:4] == 2'b01 || r_s2[5:4] == 2'b10;
  assign w_evt   = w_valid && r_s2 == r_s1 && r_s2 != r_last;
  assign w_full  = r_count == 4'(DEPTH);
  assign w_push  = w_evt && !w_full;
  assign w_pop   = start && r_state == IDLE && r_count != 0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= key_code;
      r_s2 <= r_s1;
    end
  end
  // Stopping acts like a soft reset of the queue but leaves the synchronizer running
  always_ff @(posedge clk) begin
    if (!rst_n || !start) begin
      r_last  <= '0;
      r_ovf   <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_evt) r_last <= r_s2;
      if (w_push) begin
        r_mem[r_wp] <= r_s2[3:0];
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_evt && w_full) r_ovf <= 1'b1;
      r_count <= r_count + 4'(w_push) - 4'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = !start            ? IDLE :
             r_state == IDLE   ? (r_count != 0 ? LOAD : IDLE) :
             r_state == LOAD   ? PLAY :
             r_state == PLAY   ? (r_cnt == 0 ? GAP : PLAY) :
                                 (r_cnt == 0 ? IDLE : GAP);
    w_cnt_next = r_state == LOAD ? CW'(NOTE_LEN - 1) :
                 r_state == PLAY ? (r_cnt == 0 ? CW'(GAP_LEN - 1) : r_cnt - 1'b1) :
                 r_state == GAP  ? r_cnt - 1'b1 : r_cnt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_div  <= '0;
      r_note <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_pop) r_note <= r_mem[r_rp];
      if (start && r_state == LOAD) r_div <= TONES[r_note];
    end
  end
  always_comb begin
    tone_en = r_state == PLAY;
    busy    = r_state != IDLE;
  end
  assign tone_div   = r_div;
  assign fifo_count = r_count;
  assign overflow   = r_ovf;
endmodule

// File: tb/tb_key_note_scheduler.sv
// tb_key_note_scheduler: directed vector table plus hand-timed sequences for queueing, overflow, stop and reset.
module tb_key_note_scheduler;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [7:0]  key_code;
  logic [17:0] tone_div;
  logic        tone_en, busy, overflow;
  logic [3:0]  fifo_count;
  int total = 0;
  int bad = 0;
  logic [17:0] notes [$];
  logic prev_en = 1'b0;
  typedef struct {
    logic [7:0] code;
    logic       v;
    int         div;
  } vec_t;
  vec_t vt [7];
  key_note_scheduler #(.CLK_HZ(50_000_000), .NOTE_LEN(10), .GAP_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_code(key_code), .tone_div(tone_div),
    .tone_en(tone_en), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (tone_en && !prev_en) notes.push_back(tone_div);
    prev_en = tone_en;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask
  task automatic wait_rise(output int e);
    e = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (tone_en) begin
        e = i;
        break;
      end
    end
  endtask
  task automatic chk_reset_outs(input string n);
    chk({n, "_div"}, tone_div, 0);
    chk({n, "_en"}, tone_en, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_cnt"}, fifo_count, 0);
    chk({n, "_ovf"}, overflow, 0);
  endtask
  initial begin
    int rise, hi, g;
    vt[0] = '{8'h15, 1'b1, 56818};
    vt[1] = '{8'h2C, 1'b1, 28409};
    vt[2] = '{8'h10, 1'b1, 95556};
    vt[3] = '{8'h35, 1'b0, 0};
    vt[4] = '{8'h20, 1'b1, 95556};
    vt[5] = '{8'h0C, 1'b0, 0};
    vt[6] = '{8'h1C, 1'b1, 28409};
    rst_n = 1'b0;
    start = 1'b1;
    key_code = 8'h00;
    ticks(2);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      key_code = vt[i].code;
      rise = 0;
      for (int e = 1; e <= 30; e++) begin
        tick();
        if (e == 3) chk("push_cnt", fifo_count, vt[i].v ? 1 : 0);
        if (tone_en) begin
          rise = e;
          break;
        end
      end
      if (vt[i].v) begin
        chk("rise_edge", rise, 5);
        chk("div", tone_div, vt[i].div);
        hi = 0;
        while (tone_en && hi < 40) begin
          tick();
          hi++;
        end
        chk("high_len", hi, 10);
        g = 0;
        while (busy && g < 40) begin
          tick();
          g++;
        end
        chk("gap_len", g, 4);
        chk("div_hold", tone_div, vt[i].div);
      end else begin
        chk("invalid_rise", rise, 0);
        chk("invalid_busy", busy, 0);
      end
    end
    // three notes queued while playing, then a long hold yields no extra event
    notes.delete();
    key_code = 8'h15;
    wait_rise(rise);
    chk("seq_rise", rise, 5);
    key_code = 8'h10;
    ticks(4);
    key_code = 8'h2C;
    ticks(4);
    key_code = 8'h10;
    ticks(100);
    chk("seq_count", notes.size(), 4);
    if (notes.size() == 4) begin
      chk("seq_n1", notes[1], 95556);
      chk("seq_n2", notes[2], 28409);
      chk("seq_n3", notes[3], 95556);
    end
    chk("seq_idle", busy, 0);
    // overflow: events every 2 edges outrun a single pop
    key_code = 8'h15;
    wait_rise(rise);
    chk("ovf_rise", rise, 5);
    for (int k = 0; k < 12; k++) begin
      key_code = (k % 2 == 1 ? 8'h20 : 8'h10) | 8'(k);
      ticks(2);
    end
    tick();
    chk("ovf_full", fifo_count, 8);
    chk("ovf_flag", overflow, 1);
    ticks(20);
    chk("ovf_sticky", overflow, 1);
    key_code = 8'h00;
    start = 1'b0;
    tick();
    chk("flush_cnt", fifo_count, 0);
    chk("flush_ovf", overflow, 0);
    chk("flush_busy", busy, 0);
    start = 1'b1;
    ticks(3);
    // push coinciding with the IDLE-to-LOAD pop
    notes.delete();
    key_code = 8'h15;
    wait_rise(rise);
    key_code = 8'h10;
    ticks(12);
    key_code = 8'h2C;
    ticks(2);
    chk("same_pre", fifo_count, 1);
    tick();
    chk("same_cnt", fifo_count, 1);
    chk("same_busy", busy, 1);
    ticks(50);
    chk("same_notes", notes.size(), 3);
    if (notes.size() == 3) begin
      chk("same_n0", notes[0], 56818);
      chk("same_n1", notes[1], 95556);
      chk("same_n2", notes[2], 28409);
    end
    // stop mid-PLAY with three queued, resume with key held
    key_code = 8'h15;
    wait_rise(rise);
    key_code = 8'h10;
    ticks(2);
    key_code = 8'h2C;
    ticks(2);
    key_code = 8'h15;
    ticks(4);
    chk("stop_pre_cnt", fifo_count, 3);
    chk("stop_pre_en", tone_en, 1);
    start = 1'b0;
    tick();
    chk("stop_en", tone_en, 0);
    chk("stop_cnt", fifo_count, 0);
    chk("stop_ovf", overflow, 0);
    chk("stop_busy", busy, 0);
    notes.delete();
    start = 1'b1;
    wait_rise(rise);
    chk("resume_rise", rise, 3);
    ticks(40);
    chk("resume_notes", notes.size(), 1);
    if (notes.size() == 1) chk("resume_div", notes[0], 56818);
    // reset mid-GAP with two queued
    key_code = 8'h10;
    wait_rise(rise);
    key_code = 8'h2C;
    ticks(2);
    key_code = 8'h15;
    ticks(2);
    key_code = 8'h00;
    ticks(7);
    chk("gap_pre_cnt", fifo_count, 2);
    chk("gap_pre_busy", busy, 1);
    chk("gap_pre_en", tone_en, 0);
    rst_n = 1'b0;
    tick();
    chk_reset_outs("midrst");
    rst_n = 1'b1;
    notes.delete();
    ticks(40);
    chk("postrst_notes", notes.size(), 0);
    chk("postrst_busy", busy, 0);
    key_code = 8'h2C;
    wait_rise(rise);
    chk("postrst_rise", rise, 5);
    chk("postrst_div", tone_div, 28409);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
